// File: rtl/msg_arbiter.sv
// Two-requester round-robin message arbiter for the matching engine.
// Stamps a 24-bit sequence header and presents each message for HOLD_CYCLES.
module msg_arbiter #(
  parameter int MSG_W       = 168,
  parameter int HOLD_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [MSG_W-1:0] req0_msg,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [MSG_W-1:0] req1_msg,
  output logic             req1_ready,
  output logic [MSG_W-1:0] msg,
  output logic             signal,
  output logic             busy,
  output logic             grant_id,
  output logic [23:0]      seq_num
);

  localparam int HDR_LO = MSG_W - 24;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  logic [1:0]       r_state;
  logic [7:0]       r_hold_cnt;
  logic             r_last_grant;
  logic             r_grant_id;
  logic             r_signal;
  logic [23:0]      r_seq_num;
  logic [MSG_W-1:0] r_msg;

  logic              w_any;
  logic              w_grant;
  logic              w_accept;
  logic [23:0]       w_seq_next;
  logic [HDR_LO-1:0] w_sel_low;
  logic              w_unused_hdr;

  assign w_any = req0_valid | req1_valid;

  // On a tie, the requester that did not win last time gets the slot.
  assign w_grant = (req0_valid & req1_valid) ? ~r_last_grant
                                             : req1_valid;

  assign w_accept = (r_state == S_IDLE) & w_any & ~reset;

  assign req0_ready = w_accept & ~w_grant;
  assign req1_ready = w_accept &  w_grant;

  assign w_seq_next = r_seq_num + 24'd1;

  assign w_sel_low = w_grant ? req1_msg[HDR_LO-1:0]
                             : req0_msg[HDR_LO-1:0];

  // Incoming headers are overwritten by the stamp.
  assign w_unused_hdr = ^{req0_msg[MSG_W-1:HDR_LO],
                          req1_msg[MSG_W-1:HDR_LO]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= 8'd0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_signal     <= 1'b0;
      r_seq_num    <= 24'd0;
      r_msg        <= '1;
    end else begin
      r_signal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state      <= S_ISSUE;
            r_msg        <= {w_seq_next, w_sel_low};
            r_signal     <= 1'b1;
            r_grant_id   <= w_grant;
            r_last_grant <= w_grant;
            r_seq_num    <= w_seq_next;
          end
        end
        S_ISSUE: begin
          if (HOLD_CYCLES > 1) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= HOLD_INIT;
          end else begin
            r_state <= S_IDLE;
            r_msg   <= '1;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt <= 8'd1) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 8'd0;
            r_msg      <= '1;
          end else begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_hold_cnt <= 8'd0;
          r_msg      <= '1;
        end
      endcase
    end
  end

  assign msg      = r_msg;
  assign signal   = r_signal;
  assign busy     = (r_state != S_IDLE);
  assign grant_id = r_grant_id;
  assign seq_num  = r_seq_num;

endmodule

// File: tb/tb_msg_arbiter.sv
// Self-checking bench for msg_arbiter: directed scenarios plus
// randomized traffic against a presentation-window reference model.
module tb_msg_arbiter;

  localparam int W = 168;
  localparam int H = 5;
  localparam logic [W-1:0] ONES = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] msg;
  logic         signal, busy, grant_id;
  logic [23:0]  seq_num;

  logic         b_v0 = 1'b0, b_v1 = 1'b0;
  logic [W-1:0] b_d0 = '0, b_d1 = '0;
  logic         b_r0, b_r1;
  logic [W-1:0] b_msg;
  logic         b_sig, b_busy, b_gid;
  logic [23:0]  b_seq;

  msg_arbiter #(.MSG_W(W), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_msg(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_msg(d1), .req1_ready(req1_ready),
    .msg(msg), .signal(signal), .busy(busy),
    .grant_id(grant_id), .seq_num(seq_num)
  );

  msg_arbiter #(.MSG_W(W), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(b_v0), .req0_msg(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_msg(b_d1), .req1_ready(b_r1),
    .msg(b_msg), .signal(b_sig), .busy(b_busy),
    .grant_id(b_gid), .seq_num(b_seq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: m_pres counts presentation cycles still owed.
  int           m_pres = 0;
  logic [W-1:0] m_msg = '1;
  logic         m_sig = 0, m_gid = 0, m_last = 1;
  logic [23:0]  m_seq = 0;
  logic         m_r0, m_r1, s_r0, s_r1;

  function automatic logic [W-1:0] rand_msg();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic tick();
    logic g;
    m_r0 = 1'b0;
    m_r1 = 1'b0;
    if (!reset && m_pres == 0 && (v0 || v1)) begin
      g = (v0 && v1) ? ~m_last : v1;
      m_r0 = ~g;
      m_r1 = g;
    end
    #1;
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    @(posedge clk);
    if (reset) begin
      m_pres = 0; m_msg = ONES; m_sig = 0;
      m_gid = 0; m_last = 1; m_seq = 0;
    end else if (m_r0 || m_r1) begin
      m_seq = m_seq + 24'd1;
      m_msg = m_r1 ? d1 : d0;
      m_msg[W-1 -: 24] = m_seq;
      m_sig = 1; m_gid = m_r1; m_last = m_r1;
      m_pres = H;
    end else begin
      m_sig = 0;
      if (m_pres > 0) begin
        m_pres = m_pres - 1;
        if (m_pres == 0) m_msg = ONES;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; v0 = 0; v1 = 0; b_v0 = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; v0 = 0; v1 = 0;
    tick();
    v0 = 1; v1 = 1;
    d0 = rand_msg(); d1 = rand_msg();
    tick();
    n_cmp++;
    if (s_r0 !== 1'b0 || s_r1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b%b want 00", s_r0, s_r1);
    end
    n_cmp++;
    if (msg !== ONES) begin
      n_bad++; $display("FAIL reset_msg: got %h want all-ones", msg);
    end
    n_cmp++;
    if ({signal, busy, grant_id} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000", {signal, busy, grant_id});
    end
    n_cmp++;
    if (seq_num !== 24'd0) begin
      n_bad++; $display("FAIL reset_seq: got %h want 0", seq_num);
    end
    v0 = 0; v1 = 0;
    reset = 0;
  endtask

  task automatic test_single();
    logic [W-1:0] exp;
    do_reset();
    d0 = rand_msg();
    d0[143:0] = {32'd1, 32'd96, 32'd0, 8'd0, 32'd0, 8'd0};
    exp = {24'd1, d0[143:0]};
    v0 = 1;
    tick();
    v0 = 0;
    n_cmp++;
    if (s_r0 !== 1'b1 || s_r1 !== 1'b0) begin
      n_bad++; $display("FAIL single_ready: got %b%b want 10", s_r0, s_r1);
    end
    n_cmp++;
    if (msg !== exp || signal !== 1'b1) begin
      n_bad++;
      $display("FAIL single_issue: got %h/%b want %h/1", msg, signal, exp);
    end
    for (int k = 1; k < H; k++) begin
      tick();
      n_cmp++;
      if (msg !== exp || signal !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL single_hold%0d: got %h sig %b busy %b want %h 0 1",
                 k, msg, signal, busy, exp);
      end
    end
    tick();
    n_cmp++;
    if (msg !== ONES || busy !== 1'b0 || grant_id !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle: got %h busy %b gid %b want all-ones 0 0",
               msg, busy, grant_id);
    end
  endtask

  task automatic test_contention();
    int strobes = 0;
    int last_cyc = 0;
    do_reset();
    v0 = 1; v1 = 1;
    d0 = rand_msg(); d1 = rand_msg();
    for (int c = 1; c <= 40 && strobes < 4; c++) begin
      tick();
      n_cmp++;
      if (s_r0 !== m_r0 || s_r1 !== m_r1) begin
        n_bad++;
        $display("FAIL cont_ready c%0d: got %b%b want %b%b",
                 c, s_r0, s_r1, m_r0, m_r1);
      end
      if (s_r0) d0 = rand_msg();
      if (s_r1) d1 = rand_msg();
      if (signal === 1'b1) begin
        n_cmp++;
        if (grant_id !== 1'(strobes % 2) || seq_num !== 24'(strobes + 1) ||
            msg !== m_msg) begin
          n_bad++;
          $display("FAIL cont_grant%0d: got gid %b seq %0d want gid %0d seq %0d",
                   strobes, grant_id, seq_num, strobes % 2, strobes + 1);
        end
        if (strobes > 0) begin
          n_cmp++;
          if (c - last_cyc != H + 1) begin
            n_bad++;
            $display("FAIL cont_spacing: got %0d want %0d", c - last_cyc, H + 1);
          end
        end
        last_cyc = c;
        strobes++;
      end
    end
    n_cmp++;
    if (strobes != 4) begin
      n_bad++; $display("FAIL cont_count: got %0d want 4", strobes);
    end
    v0 = 0; v1 = 0;
    repeat (H + 1) tick();
  endtask

  task automatic test_busy_stall();
    logic [W-1:0] keep;
    int got = 0;
    do_reset();
    v0 = 1; d0 = rand_msg();
    tick();
    v0 = 0;
    tick(); tick();
    v1 = 1; d1 = rand_msg(); keep = d1;
    for (int c = 1; c <= 10 && got == 0; c++) begin
      tick();
      if (s_r1) got = c;
    end
    v1 = 0;
    n_cmp++;
    if (got != 4) begin
      n_bad++; $display("FAIL stall_accept_cycle: got %0d want 4", got);
    end
    n_cmp++;
    if (msg !== {24'd2, keep[W-25:0]} || grant_id !== 1'b1 || seq_num !== 24'd2) begin
      n_bad++;
      $display("FAIL stall_msg: got %h gid %b seq %0d want %h 1 2",
               msg, grant_id, seq_num, {24'd2, keep[W-25:0]});
    end
    repeat (H + 1) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.r_seq_num = 24'hFFFFFF;
    tick();
    release dut.r_seq_num;
    m_seq = 24'hFFFFFF;
    tick();
    n_cmp++;
    if (seq_num !== 24'hFFFFFF) begin
      n_bad++; $display("FAIL wrap_preload: got %h want ffffff", seq_num);
    end
    v0 = 1; d0 = rand_msg();
    tick();
    v0 = 0;
    n_cmp++;
    if (msg !== {24'd0, d0[W-25:0]} || seq_num !== 24'd0 || signal !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_stamp: got hdr %h seq %h sig %b want 0 0 1",
               msg[W-1 -: 24], seq_num, signal);
    end
    repeat (H + 1) tick();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    v0 = 1; d0 = rand_msg();
    tick();
    v0 = 0;
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b1 || msg !== m_msg) begin
      n_bad++; $display("FAIL midhold_busy: got %b want 1", busy);
    end
    reset = 1; v0 = 1; v1 = 1;
    d0 = rand_msg(); d1 = rand_msg();
    tick();
    n_cmp++;
    if (s_r0 !== 1'b0 || s_r1 !== 1'b0) begin
      n_bad++; $display("FAIL midhold_ready_in_reset: got %b%b want 00", s_r0, s_r1);
    end
    n_cmp++;
    if (msg !== ONES || busy !== 1'b0 || seq_num !== 24'd0 || signal !== 1'b0) begin
      n_bad++;
      $display("FAIL midhold_reset: got busy %b seq %h sig %b want 0 0 0",
               busy, seq_num, signal);
    end
    reset = 0;
    tick();
    n_cmp++;
    if (s_r0 !== 1'b1 || s_r1 !== 1'b0 || grant_id !== 1'b0 || seq_num !== 24'd1) begin
      n_bad++;
      $display("FAIL midhold_first_grant: got rdy %b%b gid %b seq %0d want 10 0 1",
               s_r0, s_r1, grant_id, seq_num);
    end
    v0 = 0; v1 = 0;
    repeat (H + 1) tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!v0 && ($urandom % 3 == 0)) begin v0 = 1; d0 = rand_msg(); end
      if (!v1 && ($urandom % 3 == 0)) begin v1 = 1; d1 = rand_msg(); end
      reset = ($urandom % 97 == 0);
      tick();
      n_cmp++;
      if (s_r0 !== m_r0 || s_r1 !== m_r1) begin
        n_bad++;
        $display("FAIL rand_ready c%0d: got %b%b want %b%b",
                 c, s_r0, s_r1, m_r0, m_r1);
      end
      if (s_r0) v0 = 0;
      if (s_r1) v1 = 0;
      n_cmp++;
      if (msg !== m_msg || signal !== m_sig || busy !== (m_pres > 0) ||
          grant_id !== m_gid || seq_num !== m_seq) begin
        n_bad++;
        $display("FAIL rand_out c%0d: got sig %b busy %b gid %b seq %h want %b %b %b %h",
                 c, signal, busy, grant_id, seq_num,
                 m_sig, (m_pres > 0), m_gid, m_seq);
      end
    end
    reset = 0; v0 = 0; v1 = 0;
    repeat (H + 1) tick();
  endtask

  task automatic test_hold1();
    logic [W-1:0] exp;
    do_reset();
    b_d0 = rand_msg();
    b_v0 = 1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k % 2 == 1) exp = {24'((k + 1) / 2), b_d0[W-25:0]};
      else exp = ONES;
      n_cmp++;
      if (b_sig !== 1'(k % 2) || b_msg !== exp || b_seq !== 24'((k + 1) / 2)) begin
        n_bad++;
        $display("FAIL hold1 k%0d: got sig %b seq %0d want sig %0d seq %0d",
                 k, b_sig, b_seq, k % 2, (k + 1) / 2);
      end
    end
    b_v0 = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, bench did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_busy_stall();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    test_hold1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
